// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front-end.
// Optional feature macro: SPI_FRAME_CHECK_EN (enables frame_err checking in spi_slave_if).
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;
    localparam int WORD_W         = SPI_DATA_WIDTH + 2;

    // Two-bit command field carried in the top of every command word.
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

    // A read-phase word is consistent when its command matches the phase it arrived in.
    function automatic logic frame_ok(input spi_state_e st, input logic [1:0] cmd);
        logic ok;
        ok = 1'b1;
        if (st == READ_ADD) begin
            ok = (cmd == CMD_RD_ADDR);
        end else if (st == READ_DATA) begin
            ok = (cmd == CMD_RD_DATA);
        end
        return ok;
    endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-load, MSB-first shift register driving MISO.
// MISO carries data[W-1] in the cycle after load, then one lower bit per cycle,
// and falls back to 0 once bit 0 has been presented.
module spi_tx_serializer
    import spi_pkg::*;
#(
    parameter int W = SPI_DATA_WIDTH
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] data,
    output logic         miso,
    output logic         busy,
    output logic         done
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]     sh_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             active_reg;
    logic             miso_reg;
    logic             done_reg;

    // Load, shift out remaining bits, then return MISO to 0 with a done pulse.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            sh_reg     <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
            miso_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                sh_reg     <= {data[W-2:0], 1'b0};
                miso_reg   <= data[W-1];
                cnt_reg    <= CNT_W'(W - 1);
                active_reg <= 1'b1;
            end else if (active_reg) begin
                if (cnt_reg != '0) begin
                    miso_reg <= sh_reg[W-1];
                    sh_reg   <= {sh_reg[W-2:0], 1'b0};
                    cnt_reg  <= cnt_reg - CNT_W'(1);
                end else begin
                    miso_reg   <= 1'b0;
                    active_reg <= 1'b0;
                    done_reg   <= 1'b1;
                end
            end
        end
    end

    assign miso = miso_reg;
    assign busy = active_reg;
    assign done = done_reg;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front-end for the single-port RAM: deserialises 10-bit command
// words from MOSI and serialises RAM read data back on MISO.
// Optional feature macro: SPI_FRAME_CHECK_EN adds frame_err and rejects read
// words whose command does not match the current read phase.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int TX_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [DATA_WIDTH+1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid
`ifdef SPI_FRAME_CHECK_EN
    ,
    output logic                  frame_err
`endif
);

    localparam int CW    = DATA_WIDTH + 2;
    localparam int CNT_W = $clog2(CW);
    localparam int TMO_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

    spi_state_e       state_reg, state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [CW-1:0]    shift_reg, shift_next;
    logic             word_done_reg, word_done_next;
    logic             wait_tx_reg, wait_tx_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic             rd_addr_seen_reg, rd_addr_seen_next;
    logic [CW-1:0]    rx_data_reg, rx_data_next;
    logic             rx_valid_reg, rx_valid_next;

    logic [CW-1:0]    word_in;
    logic             word_ok;
    logic             tx_accept;
    logic             tmo_hit;
    logic             ser_load;
    logic             ser_clear;
    logic             ser_miso;
    logic             ser_busy;
    logic             ser_done_unused;

    // The word as it stands once the current MOSI bit is shifted in.
    assign word_in = {shift_reg[CW-2:0], MOSI};

`ifdef SPI_FRAME_CHECK_EN
    logic frame_err_reg, frame_err_next;
    assign word_ok   = frame_ok(state_reg, word_in[CW-1 -: 2]);
    assign frame_err = frame_err_reg;
`else
    assign word_ok = 1'b1;
`endif

    // Never reload the serializer while a previous byte is still going out.
    assign tx_accept = wait_tx_reg && tx_valid && !ser_busy;
    assign tmo_hit   = (TX_TIMEOUT != 0) && (tmo_cnt_reg == TMO_W'(TX_TIMEOUT - 1));

    // State and datapath registers, all cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            word_done_reg    <= 1'b0;
            wait_tx_reg      <= 1'b0;
            tmo_cnt_reg      <= '0;
            rd_addr_seen_reg <= 1'b0;
            rx_data_reg      <= '0;
            rx_valid_reg     <= 1'b0;
`ifdef SPI_FRAME_CHECK_EN
            frame_err_reg    <= 1'b0;
`endif
        end else begin
            state_reg        <= state_next;
            bit_cnt_reg      <= bit_cnt_next;
            shift_reg        <= shift_next;
            word_done_reg    <= word_done_next;
            wait_tx_reg      <= wait_tx_next;
            tmo_cnt_reg      <= tmo_cnt_next;
            rd_addr_seen_reg <= rd_addr_seen_next;
            rx_data_reg      <= rx_data_next;
            rx_valid_reg     <= rx_valid_next;
`ifdef SPI_FRAME_CHECK_EN
            frame_err_reg    <= frame_err_next;
`endif
        end
    end

    // Next-state logic: frame start, command decode, word capture, read-data wait.
    always_comb begin
        state_next        = state_reg;
        bit_cnt_next      = bit_cnt_reg;
        shift_next        = shift_reg;
        word_done_next    = word_done_reg;
        wait_tx_next      = wait_tx_reg;
        tmo_cnt_next      = tmo_cnt_reg;
        rd_addr_seen_next = rd_addr_seen_reg;
        rx_data_next      = rx_data_reg;
        rx_valid_next     = 1'b0;
        ser_load          = 1'b0;
        ser_clear         = 1'b0;
`ifdef SPI_FRAME_CHECK_EN
        frame_err_next    = 1'b0;
`endif
        unique case (state_reg)
            IDLE: begin
                bit_cnt_next   = '0;
                word_done_next = 1'b0;
                wait_tx_next   = 1'b0;
                tmo_cnt_next   = '0;
                if (!SS_n) begin
                    state_next = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    state_next = IDLE;
                end else begin
                    shift_next   = CW'(MOSI);
                    bit_cnt_next = '0;
                    if (!MOSI) begin
                        state_next = WRITE;
                    end else if (rd_addr_seen_reg) begin
                        state_next = READ_DATA;
                    end else begin
                        state_next = READ_ADD;
                    end
                end
            end
            default: begin
                // WRITE, READ_ADD and READ_DATA share the word capture path.
                if (SS_n) begin
                    // Deselect discards any partial word and silences MISO.
                    state_next   = IDLE;
                    ser_clear    = 1'b1;
                    wait_tx_next = 1'b0;
                end else if (!word_done_reg) begin
                    shift_next   = word_in;
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    if (bit_cnt_reg == CNT_W'(CW - 2)) begin
                        word_done_next = 1'b1;
                        if (word_ok) begin
                            rx_data_next  = word_in;
                            rx_valid_next = 1'b1;
                            if (state_reg == READ_ADD) begin
                                rd_addr_seen_next = 1'b1;
                            end
                            if (state_reg == READ_DATA) begin
                                wait_tx_next = 1'b1;
                                tmo_cnt_next = '0;
                            end
                        end
`ifdef SPI_FRAME_CHECK_EN
                        else begin
                            frame_err_next = 1'b1;
                        end
`endif
                    end
                end else if (wait_tx_reg) begin
                    if (tx_accept) begin
                        ser_load          = 1'b1;
                        wait_tx_next      = 1'b0;
                        rd_addr_seen_next = 1'b0;
                    end else if (tmo_hit) begin
                        wait_tx_next      = 1'b0;
                        rd_addr_seen_next = 1'b0;
                    end else begin
                        tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                    end
                end
            end
        endcase
    end

    // Completion pulse is not needed here; the FSM already knows when readout started.
    spi_tx_serializer #(
        .W (DATA_WIDTH)
    ) u_tx (
        .clk   (clk),
        .srst  (rst),
        .clear (ser_clear),
        .load  (ser_load),
        .data  (tx_data),
        .miso  (ser_miso),
        .busy  (ser_busy),
        .done  (ser_done_unused)
    );

    assign MISO     = ser_miso;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;

endmodule
